// File: rtl/pcie_dll_pkg.sv
// Shared data-link-layer definitions: DLLP type codes, FC state encoding,
// FC type indices and DLLP field extraction helpers.
package pcie_dll_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h100B;
   localparam logic [15:0] CRC16_SEED = 16'hFFFF;

   // Fixed-value DLLP type bytes
   typedef enum logic [7:0] {
      DLLP_ACK = 8'h00,
      DLLP_NAK = 8'h10,
      DLLP_NOP = 8'h31
   } dllp_type_e;

   // FC DLLP class lives in type[7:6]; type[5:4] selects P/NP/Cpl
   typedef enum logic [1:0] {
      FC_CLS_INIT1 = 2'b01,
      FC_CLS_UPD   = 2'b10,
      FC_CLS_INIT2 = 2'b11
   } fc_class_e;

   typedef enum logic [1:0] {
      FC_P   = 2'd0,
      FC_NP  = 2'd1,
      FC_CPL = 2'd2
   } fc_type_e;

   typedef enum logic [1:0] {
      FC_IDLE  = 2'd0,
      FC_INIT1 = 2'd1,
      FC_INIT2 = 2'd2,
      FC_DONE  = 2'd3
   } fc_state_e;

   typedef enum logic [2:0] {
      DK_NONE,
      DK_ACK,
      DK_NAK,
      DK_INITFC1,
      DK_INITFC2,
      DK_UPDFC
   } dllp_kind_e;

   function automatic logic [11:0] dllp_seq(input logic [31:0] d);
      return {d[19:16], d[31:24]};
   endfunction

   function automatic logic [7:0] dllp_hdr_fc(input logic [31:0] d);
      return {d[13:8], d[23:22]};
   endfunction

   function automatic logic [11:0] dllp_data_fc(input logic [31:0] d);
      return {d[19:16], d[31:24]};
   endfunction

   function automatic fc_type_e dllp_fc_type(input logic [7:0] t);
      return fc_type_e'(t[5:4]);
   endfunction

   // FC DLLPs only count for our VC (bit3 must be 0); anything else is discarded
   function automatic dllp_kind_e dllp_decode(input logic [7:0] t, input logic [2:0] vc);
      dllp_kind_e k;
      k = DK_NONE;
      if (t == DLLP_ACK) begin
         k = DK_ACK;
      end else if (t == DLLP_NAK) begin
         k = DK_NAK;
      end else if (t[3] == 1'b0 && t[2:0] == vc && t[5:4] != 2'b11) begin
         case (t[7:6])
            FC_CLS_INIT1: k = DK_INITFC1;
            FC_CLS_INIT2: k = DK_INITFC2;
            FC_CLS_UPD:   k = DK_UPDFC;
            default:      k = DK_NONE;
         endcase
      end
      return k;
   endfunction

endpackage

// File: rtl/pcie_dllp_crc16.sv
// DLLP CRC16 over the four DLLP bytes, bits taken byte 0 first, LSB first.
// Output is already in wire order: [7:0] is byte 4, [15:8] is byte 5.
module pcie_dllp_crc16
   import pcie_dll_pkg::*;
(
   input  logic [31:0] data_i,
   output logic [15:0] crc_o
);

   logic [15:0] lfsr;
   logic        fb;

   // Bit-serial LFSR unrolled, then complement and per-byte bit reversal
   always_comb begin
      lfsr  = CRC16_SEED;
      fb    = 1'b0;
      crc_o = '0;
      for (int i = 0; i < 32; i++) begin
         fb   = lfsr[15] ^ data_i[i];
         lfsr = {lfsr[14:0], 1'b0};
         if (fb) lfsr = lfsr ^ CRC16_POLY;
      end
      for (int b = 0; b < 8; b++) begin
         crc_o[b]     = ~lfsr[15-b];
         crc_o[8 + b] = ~lfsr[7-b];
      end
   end

endmodule

// File: rtl/pcie_dllp_rx.sv
// DLLP receiver: CRC check, Ack/Nak reporting and flow-control init tracking.
// Stage 1 registers the DLLP and its CRC verdict, stage 2 acts on it.
//
//   state    | meaning
//   FC_IDLE  | link down, limits cleared
//   FC_INIT1 | collecting InitFC1 for P, NP and Cpl
//   FC_INIT2 | all InitFC1 seen, waiting for first InitFC2/UpdateFC
//   FC_DONE  | initialised, UpdateFC refreshes limits
module pcie_dllp_rx
   import pcie_dll_pkg::*;
#(
   parameter logic [2:0] VC_ID = 3'd0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             link_up_i,
   input  logic             dllp_valid_i,
   input  logic [47:0]      dllp_i,
   output logic             ack_valid_o,
   output logic             nak_valid_o,
   output logic [11:0]      acknak_seq_o,
   output logic [2:0][7:0]  fc_hdr_cl_o,
   output logic [2:0][11:0] fc_data_cl_o,
   output logic [1:0]       fc_state_o,
   output logic             crc_err_o,
   output logic [15:0]      crc_err_cnt_o
);

   logic [15:0]      crc_calc;
   logic             s1_valid_q;
   logic             s1_crc_ok_q;
   logic [31:0]      s1_dllp_q;
   fc_state_e        state_q, state_d;
   logic [2:0]       seen_q, seen_d;
   logic [2:0][7:0]  hdr_cl_q, hdr_cl_d;
   logic [2:0][11:0] data_cl_q, data_cl_d;
   logic [11:0]      seq_q, seq_d;
   logic             ack_q, ack_d;
   logic             nak_q, nak_d;
   logic             err_q, err_d;
   logic [15:0]      err_cnt_q, err_cnt_d;
   dllp_kind_e       kind;
   fc_type_e         fc_idx;

   pcie_dllp_crc16 u_crc (
      .data_i (dllp_i[31:0]),
      .crc_o  (crc_calc)
   );

   // Stage 1: capture the DLLP together with its CRC verdict
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_crc_ok_q <= 1'b0;
         s1_dllp_q   <= '0;
      end else begin
         s1_valid_q  <= dllp_valid_i;
         s1_crc_ok_q <= (crc_calc == dllp_i[47:32]);
         s1_dllp_q   <= dllp_i[31:0];
      end
   end

   // Decode the stage-1 DLLP; a bad-CRC DLLP decodes to nothing
   always_comb begin
      kind   = DK_NONE;
      fc_idx = dllp_fc_type(s1_dllp_q[7:0]);
      if (s1_valid_q && s1_crc_ok_q) kind = dllp_decode(s1_dllp_q[7:0], VC_ID);
   end

   // Stage 2 next state: error accounting, Ack/Nak, FC init FSM
   always_comb begin
      state_d   = state_q;
      seen_d    = seen_q;
      hdr_cl_d  = hdr_cl_q;
      data_cl_d = data_cl_q;
      seq_d     = seq_q;
      err_cnt_d = err_cnt_q;
      ack_d     = 1'b0;
      nak_d     = 1'b0;
      err_d     = 1'b0;

      if (s1_valid_q && !s1_crc_ok_q) begin
         err_d = 1'b1;
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end

      // Ack/Nak are honoured regardless of FC state or link
      if (kind == DK_ACK || kind == DK_NAK) begin
         seq_d = dllp_seq(s1_dllp_q);
         ack_d = (kind == DK_ACK);
         nak_d = (kind == DK_NAK);
      end

      if (!link_up_i) begin
         state_d   = FC_IDLE;
         seen_d    = '0;
         hdr_cl_d  = '0;
         data_cl_d = '0;
      end else begin
         case (state_q)
            FC_IDLE: state_d = FC_INIT1;
            FC_INIT1: begin
               if (kind == DK_INITFC1) begin
                  hdr_cl_d[fc_idx]  = dllp_hdr_fc(s1_dllp_q);
                  data_cl_d[fc_idx] = dllp_data_fc(s1_dllp_q);
                  seen_d[fc_idx]    = 1'b1;
                  if (&seen_d) state_d = FC_INIT2;
               end
            end
            FC_INIT2: begin
               if (kind == DK_UPDFC) begin
                  hdr_cl_d[fc_idx]  = dllp_hdr_fc(s1_dllp_q);
                  data_cl_d[fc_idx] = dllp_data_fc(s1_dllp_q);
               end
               if (kind == DK_INITFC2 || kind == DK_UPDFC) state_d = FC_DONE;
            end
            FC_DONE: begin
               if (kind == DK_UPDFC) begin
                  hdr_cl_d[fc_idx]  = dllp_hdr_fc(s1_dllp_q);
                  data_cl_d[fc_idx] = dllp_data_fc(s1_dllp_q);
               end
            end
            default: state_d = FC_IDLE;
         endcase
      end
   end

   // Stage 2 registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FC_IDLE;
         seen_q    <= '0;
         hdr_cl_q  <= '0;
         data_cl_q <= '0;
         seq_q     <= 12'hFFF;
         ack_q     <= 1'b0;
         nak_q     <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         seen_q    <= seen_d;
         hdr_cl_q  <= hdr_cl_d;
         data_cl_q <= data_cl_d;
         seq_q     <= seq_d;
         ack_q     <= ack_d;
         nak_q     <= nak_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign ack_valid_o   = ack_q;
   assign nak_valid_o   = nak_q;
   assign acknak_seq_o  = seq_q;
   assign fc_hdr_cl_o   = hdr_cl_q;
   assign fc_data_cl_o  = data_cl_q;
   assign fc_state_o    = state_q;
   assign crc_err_o     = err_q;
   assign crc_err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_pcie_dllp_rx.sv
// Scoreboard bench for pcie_dllp_rx with a behavioural reference model.
`timescale 1ns/1ps
module tb_pcie_dllp_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n, link_up_i, dllp_valid_i;
   logic [47:0]      dllp_i;
   logic             ack_valid_o, nak_valid_o, crc_err_o;
   logic [11:0]      acknak_seq_o;
   logic [2:0][7:0]  fc_hdr_cl_o;
   logic [2:0][11:0] fc_data_cl_o;
   logic [1:0]       fc_state_o;
   logic [15:0]      crc_err_cnt_o;

   pcie_dllp_rx #(.VC_ID(3'd0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .link_up_i     (link_up_i),
      .dllp_valid_i  (dllp_valid_i),
      .dllp_i        (dllp_i),
      .ack_valid_o   (ack_valid_o),
      .nak_valid_o   (nak_valid_o),
      .acknak_seq_o  (acknak_seq_o),
      .fc_hdr_cl_o   (fc_hdr_cl_o),
      .fc_data_cl_o  (fc_data_cl_o),
      .fc_state_o    (fc_state_o),
      .crc_err_o     (crc_err_o),
      .crc_err_cnt_o (crc_err_cnt_o)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        ack;
      logic        nak;
      logic        err;
      logic [11:0] seq;
      logic [15:0] cnt;
   } pulse_t;
   pulse_t sb_q[$];

   typedef struct {
      logic [1:0]  st;
      logic [23:0] hdr;
      logic [35:0] data;
      logic [11:0] seq;
      logic [15:0] cnt;
      string       nm;
   } dir_t;
   dir_t dir_q[$];

   // Reference model state: 0 idle, 1 init1, 2 init2, 3 done
   int          m_state;
   logic        m_seen[3];
   logic [7:0]  m_hdr[3];
   logic [11:0] m_data[3];
   logic [11:0] m_seq;
   int          m_cnt;
   logic        p_valid;
   logic [47:0] p_dllp;

   logic [3:0] fc_nib [9] = '{4'h4, 4'h5, 4'h6, 4'hC, 4'hD, 4'hE, 4'h8, 4'h9, 4'hA};

   // CRC by polynomial long division of the augmented message; the seed is
   // folded in by inverting the first 16 transmitted bits
   function automatic logic [15:0] ref_crc(input logic [31:0] d);
      logic [47:0] v;
      logic [15:0] r;
      logic [7:0]  b4, b5;
      v = '0;
      for (int i = 0; i < 32; i++) v[47-i] = d[i];
      v[47:32] = ~v[47:32];
      for (int i = 47; i >= 16; i--)
         if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h1100B;
      r = v[15:0];
      for (int b = 0; b < 8; b++) begin
         b4[b] = ~r[15-b];
         b5[b] = ~r[7-b];
      end
      return {b5, b4};
   endfunction

   function automatic logic [47:0] mk_dllp(input logic [31:0] d);
      return {ref_crc(d), d};
   endfunction

   function automatic logic [31:0] fc_body(input logic [7:0] t, input logic [7:0] h, input logic [11:0] dt);
      logic [31:0] d;
      d = $urandom;
      d[7:0] = t;
      d[13:8] = h[7:2];
      d[23:22] = h[1:0];
      d[19:16] = dt[11:8];
      d[31:24] = dt[7:0];
      return d;
   endfunction

   function automatic logic [31:0] an_body(input logic [7:0] t, input logic [11:0] s);
      logic [31:0] d;
      d = $urandom;
      d[7:0] = t;
      d[19:16] = s[11:8];
      d[31:24] = s[7:0];
      return d;
   endfunction

   // 0 none, 1 ack, 2 nak, 3 InitFC1, 4 InitFC2, 5 UpdateFC; idx 0=P 1=NP 2=Cpl
   function automatic int ref_kind(input logic [7:0] t, output int idx);
      idx = 0;
      if (t == 8'h00) return 1;
      if (t == 8'h10) return 2;
      if (t[3:0] != 4'h0) return 0;
      case (t[7:4])
         4'h4, 4'h5, 4'h6: begin idx = int'(t[7:4]) - 4;  return 3; end
         4'hC, 4'hD, 4'hE: begin idx = int'(t[7:4]) - 12; return 4; end
         4'h8, 4'h9, 4'hA: begin idx = int'(t[7:4]) - 8;  return 5; end
         default: return 0;
      endcase
   endfunction

   task automatic model_clear_fc();
      for (int i = 0; i < 3; i++) begin
         m_seen[i] = 1'b0;
         m_hdr[i]  = 8'h00;
         m_data[i] = 12'h000;
      end
   endtask

   // What happens at one clock edge: pd is the DLLP issued one cycle earlier
   task automatic model_step(input logic rst, input logic link, input logic pv, input logic [47:0] pd);
      pulse_t e;
      int     k, idx;
      logic   good;
      if (!rst) begin
         m_state = 0;
         model_clear_fc();
         m_seq = 12'hFFF;
         m_cnt = 0;
         return;
      end
      e.ack = 1'b0; e.nak = 1'b0; e.err = 1'b0; e.seq = m_seq; e.cnt = 16'(m_cnt);
      idx = 0;
      good = pv && (ref_crc(pd[31:0]) == pd[47:32]);
      k = good ? ref_kind(pd[7:0], idx) : 0;
      if (pv && !good) begin
         if (m_cnt < 65535) m_cnt++;
         e.err = 1'b1;
         e.cnt = 16'(m_cnt);
         sb_q.push_back(e);
      end
      if (k == 1 || k == 2) begin
         m_seq = {pd[19:16], pd[31:24]};
         e.ack = (k == 1);
         e.nak = (k == 2);
         e.seq = m_seq;
         sb_q.push_back(e);
      end
      if (!link) begin
         m_state = 0;
         model_clear_fc();
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1 && k == 3) begin
         m_hdr[idx]  = {pd[13:8], pd[23:22]};
         m_data[idx] = {pd[19:16], pd[31:24]};
         m_seen[idx] = 1'b1;
         if (m_seen[0] && m_seen[1] && m_seen[2]) m_state = 2;
      end else if (m_state == 2 && (k == 4 || k == 5)) begin
         if (k == 5) begin
            m_hdr[idx]  = {pd[13:8], pd[23:22]};
            m_data[idx] = {pd[19:16], pd[31:24]};
         end
         m_state = 3;
      end else if (m_state == 3 && k == 5) begin
         m_hdr[idx]  = {pd[13:8], pd[23:22]};
         m_data[idx] = {pd[19:16], pd[31:24]};
      end
   endtask

   task automatic drive(input logic rst, input logic link, input logic v, input logic [47:0] d);
      rst_n = rst; link_up_i = link; dllp_valid_i = v; dllp_i = d;
      @(posedge clk);
      model_step(rst, link, p_valid, p_dllp);
      if (!rst) begin
         p_valid = 1'b0;
      end else begin
         p_valid = v;
         p_dllp  = d;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, link_up_i, 1'b0, 48'h0);
   endtask

   task automatic dir(input logic [1:0] st, input logic [23:0] h, input logic [35:0] dt,
                      input logic [11:0] s, input logic [15:0] c, input string nm);
      dir_t x;
      x.st = st; x.hdr = h; x.data = dt; x.seq = s; x.cnt = c; x.nm = nm;
      dir_q.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Monitor: pops expected pulses and compares the DUT against the model every cycle
   always @(negedge clk) begin : mon
      pulse_t      e;
      dir_t        x;
      logic [2:0]  got, want;
      got  = {ack_valid_o, nak_valid_o, crc_err_o};
      want = 3'b000;
      e.ack = 1'b0; e.nak = 1'b0; e.err = 1'b0; e.seq = '0; e.cnt = '0;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         want = {e.ack, e.nak, e.err};
      end
      chk("pulses{ack,nak,err}", 64'(got), 64'(want));
      if (want[2] || want[1]) chk("pulse_seq", 64'(acknak_seq_o), 64'(e.seq));
      if (want[0]) chk("pulse_err_cnt", 64'(crc_err_cnt_o), 64'(e.cnt));
      chk("fc_state", 64'(fc_state_o), 64'(m_state));
      chk("fc_hdr_cl", 64'(fc_hdr_cl_o), 64'({m_hdr[2], m_hdr[1], m_hdr[0]}));
      chk("fc_data_cl", 64'(fc_data_cl_o), 64'({m_data[2], m_data[1], m_data[0]}));
      chk("acknak_seq", 64'(acknak_seq_o), 64'(m_seq));
      chk("crc_err_cnt", 64'(crc_err_cnt_o), 64'(m_cnt));
      if (dir_q.size() > 0) begin
         x = dir_q.pop_front();
         chk({x.nm, ".state"}, 64'(fc_state_o), 64'(x.st));
         chk({x.nm, ".hdr"}, 64'(fc_hdr_cl_o), 64'(x.hdr));
         chk({x.nm, ".data"}, 64'(fc_data_cl_o), 64'(x.data));
         chk({x.nm, ".seq"}, 64'(acknak_seq_o), 64'(x.seq));
         chk({x.nm, ".cnt"}, 64'(crc_err_cnt_o), 64'(x.cnt));
      end
   end

   initial begin : main
      logic [47:0] d;
      logic        link, v, rst;
      logic [7:0]  t;
      logic [3:0]  vcn;
      int          r;
      rst_n = 1'b0; link_up_i = 1'b0; dllp_valid_i = 1'b0; dllp_i = '0;
      p_valid = 1'b0; p_dllp = '0;

      repeat (3) drive(1'b0, 1'b0, 1'b0, 48'h0);
      dir(2'd0, 24'h0, 36'h0, 12'hFFF, 16'h0, "reset");

      drive(1'b1, 1'b1, 1'b0, 48'h0);
      drive(1'b1, 1'b1, 1'b0, 48'h0);
      dir(2'd1, 24'h0, 36'h0, 12'hFFF, 16'h0, "link_up");

      drive(1'b1, 1'b1, 1'b1, mk_dllp(fc_body(8'h40, 8'h20, 12'h100)));
      drive(1'b1, 1'b1, 1'b1, mk_dllp(fc_body(8'h50, 8'h20, 12'h100)));
      drive(1'b1, 1'b1, 1'b1, mk_dllp(fc_body(8'h60, 8'h20, 12'h100)));
      dir(2'd1, 24'h002020, 36'h000100100, 12'hFFF, 16'h0, "initfc1_partial");
      idle(2);
      dir(2'd2, 24'h202020, 36'h100100100, 12'hFFF, 16'h0, "initfc1_all");

      drive(1'b1, 1'b1, 1'b1, mk_dllp(fc_body(8'h90, 8'h08, 12'h040)));
      idle(2);
      dir(2'd3, 24'h200820, 36'h100040100, 12'hFFF, 16'h0, "updfc_np");

      drive(1'b1, 1'b1, 1'b1, mk_dllp(an_body(8'h00, 12'h123)));
      idle(2);
      dir(2'd3, 24'h200820, 36'h100040100, 12'h123, 16'h0, "ack_123");

      d = mk_dllp(an_body(8'h10, 12'hABC));
      d[32] = ~d[32];
      drive(1'b1, 1'b1, 1'b1, d);
      idle(2);
      dir(2'd3, 24'h200820, 36'h100040100, 12'h123, 16'h1, "nak_bad_crc");

      drive(1'b1, 1'b1, 1'b1, mk_dllp(fc_body(8'h40, 8'h11, 12'h111)));
      drive(1'b1, 1'b1, 1'b1, mk_dllp(fc_body(8'h50, 8'h11, 12'h111)));
      drive(1'b1, 1'b1, 1'b1, mk_dllp(fc_body(8'h60, 8'h11, 12'h111)));
      drive(1'b1, 1'b0, 1'b0, 48'h0);
      dir(2'd0, 24'h0, 36'h0, 12'h123, 16'h1, "link_down");

      drive(1'b1, 1'b1, 1'b0, 48'h0);
      drive(1'b1, 1'b1, 1'b1, mk_dllp(an_body(8'h00, 12'h055)));
      drive(1'b0, 1'b1, 1'b1, mk_dllp(an_body(8'h00, 12'h066)));
      drive(1'b0, 1'b1, 1'b0, 48'h0);
      dir(2'd0, 24'h0, 36'h0, 12'hFFF, 16'h0, "midstream_reset");

      link = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (link) begin
            if ($urandom_range(0, 99) == 0) link = 1'b0;
         end else if ($urandom_range(0, 9) < 3) begin
            link = 1'b1;
         end
         rst = ($urandom_range(0, 499) != 0);
         v   = ($urandom_range(0, 9) < 8);
         r   = $urandom_range(0, 15);
         vcn = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         if (r == 0)      t = 8'h00;
         else if (r == 1) t = 8'h10;
         else if (r == 2) t = 8'h31;
         else if (r == 3) t = 8'($urandom);
         else             t = {fc_nib[r - 4 - (r > 12 ? 9 : 0)], vcn};
         if (r == 0 || r == 1)
            d = mk_dllp(an_body(t, 12'($urandom)));
         else
            d = mk_dllp(fc_body(t, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 12'($urandom)));
         if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 47)] ^= 1'b1;
         drive(rst, link, v, d);
      end
      idle(3);

      for (int i = 0; i < 65536; i++) begin
         d = mk_dllp(32'($urandom));
         d[40] = ~d[40];
         drive(1'b1, link_up_i, 1'b1, d);
      end
      idle(3);
      dir(2'(m_state), {m_hdr[2], m_hdr[1], m_hdr[0]}, {m_data[2], m_data[1], m_data[0]},
          m_seq, 16'hFFFF, "crc_cnt_saturate");
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pcie_dllp_rx.md
PCIE_DLLP_RX -- requirements
Module: pcie_dllp_rx

Interface
REQ-001 SHALL have parameter: VC_ID, 3'd0, only virtual channel whose FC DLLPs are accepted.
REQ-002 SHALL have port: clk  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: link_up_i  in  1  DL up; low forces FC_IDLE and clears state.
REQ-005 SHALL have port: dllp_valid_i  in  1  one received DLLP present this cycle; no backpressure.
REQ-006 SHALL have port: dllp_i  in  48  DLLP; [7:0] type byte, [31:8] bytes 1..3, [47:32] received CRC16.
REQ-007 SHALL have port: ack_valid_o  out  1  one-cycle pulse, good Ack received.
REQ-008 SHALL have port: nak_valid_o  out  1  one-cycle pulse, good Nak received.
REQ-009 SHALL have port: acknak_seq_o  out  12  sequence number of last good Ack/Nak.
REQ-010 SHALL have port: fc_hdr_cl_o  out  3x8  header credit limit; index 0=P, 1=NP, 2=Cpl.
REQ-011 SHALL have port: fc_data_cl_o  out  3x12  data credit limit, same indexing.
REQ-012 SHALL have port: fc_state_o  out  2  0=FC_IDLE, 1=FC_INIT1, 2=FC_INIT2, 3=FC_DONE.
REQ-013 SHALL have port: crc_err_o  out  1  one-cycle pulse, DLLP discarded for bad CRC.
REQ-014 SHALL have port: crc_err_cnt_o  out  16  saturating count of bad-CRC DLLPs.

Function
REQ-015 SHALL compute PCIe DLLP CRC16 (poly 100Bh, seed FFFFh, spec bit ordering/complement) over dllp_i[31:0] and compare with dllp_i[47:32].
REQ-016 SHALL register input in stage 1 (data, valid, CRC-match) and act in stage 2; outputs reflect a DLLP exactly 2 cycles after dllp_valid_i.
REQ-017 SHALL accept one DLLP every cycle at full rate with no loss.
REQ-018 SHALL, on CRC mismatch, pulse crc_err_o, increment crc_err_cnt_o (saturate at FFFFh), change nothing else.
REQ-019 SHALL decode type: 00h Ack, 10h Nak, 4vh/5vh/6vh InitFC1-P/NP/Cpl, Cvh/Dvh/Evh InitFC2-P/NP/Cpl, 8vh/9vh/Avh UpdateFC-P/NP/Cpl, v=0,VC_ID (bit3=0).
REQ-020 SHALL silently discard NOP (31h), FC types with other VC, and all other types.
REQ-021 SHALL extract seq = {dllp_i[19:16], dllp_i[31:24]}, hdrFC = {dllp_i[13:8], dllp_i[23:22]}, dataFC = {dllp_i[19:16], dllp_i[31:24]}; scale fields ignored.
REQ-022 SHALL, for good Ack/Nak, load acknak_seq_o and pulse ack_valid_o/nak_valid_o, in any FC state including FC_IDLE.
REQ-023 SHALL move FC_IDLE->FC_INIT1 in the cycle after link_up_i is sampled high.
REQ-024 SHALL, in FC_INIT1, load limits from each InitFC1, set per-type seen flag; when all three flags set (incl. same-cycle update) go to FC_INIT2.
REQ-025 SHALL, in FC_INIT1, ignore InitFC2 and UpdateFC; repeated InitFC1 of same type overwrites limit.
REQ-026 SHALL, in FC_INIT2, go to FC_DONE on first good InitFC2 or UpdateFC of any type; UpdateFC also loads its limit; InitFC1/InitFC2 do not load.
REQ-027 SHALL, in FC_DONE, load limit for type on UpdateFC; ignore InitFC1/InitFC2.
REQ-028 SHALL treat limit value 0 as a plain value (infinite-credit meaning is user's concern).
REQ-029 SHALL, when link_up_i sampled low, next cycle enter FC_IDLE, clear seen flags and limits to 0, and drop any stage-2 FC action in that cycle; Ack/Nak still processed.

Reset
REQ-030 SHALL on rst_n low: fc_state_o=FC_IDLE, limits 0, seen flags 0, acknak_seq_o=FFFh, all pulses 0, crc_err_cnt_o 0, pipeline valids 0.
REQ-031 SHALL discard any DLLP in flight when reset asserts mid-stream.

Structure
REQ-032 SHALL place DLLP type codes, FC state enum, fc type index constants and field-extract helpers in the shared _PCIE_DLL_PKG.
REQ-033 SHALL implement CRC16 in combinational sub-module pcie_dllp_crc16 (32-bit in, 16-bit out), reusable by the transmitter.

Verification
REQ-034 SHALL check: link_up_i=1, InitFC1 P/NP/Cpl hdr 20h/data 100h each -> state INIT1 then INIT2, limits 20h/100h.
REQ-035 SHALL check: in INIT2 UpdateFC-NP hdr 08h data 040h -> state DONE, NP limits 08h/040h, P/Cpl unchanged.
REQ-036 SHALL check: Ack seq 123h, good CRC -> ack_valid_o pulse 2 cycles later, acknak_seq_o=123h.
REQ-037 SHALL check: Nak seq ABCh with CRC bit 0 flipped -> crc_err_o pulse, count +1, acknak_seq_o unchanged, no nak pulse.
REQ-038 SHALL check: back-to-back 3 InitFC1 then link_up_i low -> FC_IDLE, all limits 0 next cycle.
REQ-039 SHALL check: 65536 bad DLLPs -> crc_err_cnt_o holds FFFFh.
